// File: rtl/hub75_shift.sv
// HUB75 line shifter: streams one bit-plane of a line buffer to the panel.
// Each column takes two cycles: a buffer read, then a low/high phy_clk pair.
module hub75_shift #(
  parameter int N_BANKS  = 2,
  parameter int N_COLS   = 64,
  parameter int N_CHANS  = 3,
  parameter int BITDEPTH = 8,
  localparam int CW = $clog2(N_COLS),
  localparam int PW = $clog2(BITDEPTH),
  localparam int DW = N_BANKS * N_CHANS * BITDEPTH,
  localparam int NL = N_BANKS * N_CHANS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] ctrl_plane,
  input  logic          ctrl_go,
  output logic          ctrl_rdy,
  output logic [CW-1:0] buf_rd_addr,
  output logic          buf_rd_ena,
  input  logic [DW-1:0] buf_rd_data,
  output logic [NL-1:0] phy_data,
  output logic          phy_clk
);

  // Cycle index within a SHIFT runs 0 .. 2*N_COLS+1, so it needs two bits above CW.
  localparam int TW = CW + 2;
  localparam logic [TW-1:0] T_LAST      = TW'(2 * N_COLS + 1);
  localparam logic [TW-1:0] T_RD_END    = TW'(2 * N_COLS);
  localparam logic [TW-1:0] T_CLK_FIRST = TW'(3);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_t;
  logic [PW-1:0] r_plane;

  logic [TW-1:0] w_t_next;
  logic          w_rd_next;
  logic          w_data_cycle;
  logic [NL-1:0] w_plane_bits;

  function automatic logic [NL-1:0] slice_plane(input logic [DW-1:0] word,
                                                input logic [PW-1:0] plane);
    logic [BITDEPTH-1:0] lane;
    slice_plane = '0;
    for (int i = 0; i < NL; i++) begin
      lane           = word[i*BITDEPTH +: BITDEPTH];
      slice_plane[i] = lane[plane];
    end
  endfunction

  assign w_t_next     = r_t + TW'(1);
  assign w_rd_next    = ~w_t_next[0] && (w_t_next < T_RD_END);
  // Read data returns on odd cycles; the last one lands at t = 2*N_COLS-1.
  assign w_data_cycle = r_t[0] && (r_t < T_RD_END);
  assign w_plane_bits = slice_plane(buf_rd_data, r_plane);

  // Sequencer: state, cycle index, latched plane and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_t         <= '0;
      r_plane     <= '0;
      ctrl_rdy    <= 1'b1;
      buf_rd_ena  <= 1'b0;
      buf_rd_addr <= '0;
      phy_data    <= '0;
      phy_clk     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          phy_clk <= 1'b0;
          if (ctrl_go) begin
            r_state     <= ST_SHIFT;
            r_t         <= '0;
            r_plane     <= ctrl_plane;
            ctrl_rdy    <= 1'b0;
            buf_rd_ena  <= 1'b1;
            buf_rd_addr <= '0;
          end else begin
            ctrl_rdy    <= 1'b1;
            buf_rd_ena  <= 1'b0;
            buf_rd_addr <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_data_cycle) begin
            phy_data <= w_plane_bits;
          end else begin
            phy_data <= phy_data;
          end
          if (r_t == T_LAST) begin
            r_state     <= ST_IDLE;
            r_t         <= '0;
            ctrl_rdy    <= 1'b1;
            buf_rd_ena  <= 1'b0;
            buf_rd_addr <= '0;
            phy_clk     <= 1'b0;
          end else begin
            r_t         <= w_t_next;
            buf_rd_ena  <= w_rd_next;
            buf_rd_addr <= w_rd_next ? w_t_next[CW:1] : '0;
            phy_clk     <= w_t_next[0] && (w_t_next >= T_CLK_FIRST);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_t         <= '0;
          r_plane     <= '0;
          ctrl_rdy    <= 1'b1;
          buf_rd_ena  <= 1'b0;
          buf_rd_addr <= '0;
          phy_data    <= '0;
          phy_clk     <= 1'b0;
        end
      endcase
    end
  end

endmodule
